pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 reset_n  in  1  synchronous reset, active-low.
REQ-003 rs_ID, rt_ID  in  2 each  source register addresses of the instruction in ID.
REQ-004 use_rs_ID, use_rt_ID  in  1 each  the ID instruction reads rs / rt.
REQ-005 halt_ID  in  1  the ID instruction is HLT.
REQ-006 d_readM_EX  in  1  the EX instruction is a load.
REQ-007 write_reg_addr_EX  in  2  destination register of the EX instruction.
REQ-008 mispredict_EX  in  1  the EX branch or jump resolved differently from branch_predicted_pc.
REQ-009 d_access_MEM  in  1  the MEM instruction reads or writes data memory.
REQ-010 d_ready  in  1  data memory completes the access this cycle.
REQ-011 i_ready  in  1  instruction memory returns a valid word this cycle.
REQ-012 is_halted_WB  in  1  HLT has reached WB.
REQ-013 pc_write  out  1  PC register loads its next value.
REQ-014 redirect  out  1  PC loads the corrected EX target instead of the predicted PC.
REQ-015 stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB  out  1 each  hold the pipeline register.
REQ-016 flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB  out  1 each  load NOP/zero into the pipeline register.
REQ-017 halted  out  1  the core is halted.
REQ-018 stall_count  out  16  saturating count of stalled cycles.

Function
REQ-019 FSM states: RUN, DRAIN, HALTED; the state register is the only control state, and all other outputs except stall_count are combinational from the state and inputs.
REQ-020 The following conditions SHALL be defined:
  dwait = d_access_MEM & ~d_ready.
  lu = d_readM_EX & ((use_rs_ID & rs_ID==write_reg_addr_EX) | (use_rt_ID & rt_ID==write_reg_addr_EX)).
  iwait = ~i_ready.
REQ-021 In RUN and DRAIN, the controller SHALL act on exactly one condition per cycle, in priority order dwait > mispredict_EX > lu > iwait.
REQ-022 dwait SHALL produce: stall_IF_ID=stall_ID_EX=stall_EX_MEM=1, flush_MEM_WB=1, pc_write=0, redirect=0; a pending mispredict_EX is held and acted on after dwait clears.
REQ-023 mispredict_EX (no dwait) SHALL produce: flush_IF_ID=flush_ID_EX=1, pc_write=1, redirect=1; lu and halt_ID are ignored that cycle.
REQ-024 lu (no dwait, no mispredict) SHALL produce: stall_IF_ID=1, flush_ID_EX=1, pc_write=0.
REQ-025 iwait only SHALL produce: flush_IF_ID=1, pc_write=0; later stages advance.
REQ-026 With no condition active, all stall/flush outputs SHALL be 0, pc_write=1, and redirect=0.
REQ-027 RUN->DRAIN SHALL occur when halt_ID=1 and no dwait, mispredict_EX or lu is active, i.e. HLT advances into EX.
REQ-028 In DRAIN, pc_write SHALL be 0 and flush_IF_ID SHALL be 1 each cycle; dwait behaves per REQ-022.
REQ-029 DRAIN->HALTED SHALL occur when is_halted_WB=1.
REQ-030 In HALTED, all four stall outputs SHALL be 1, all flush outputs 0, pc_write=0, redirect=0, halted=1; HALTED is left only by reset.
REQ-031 stall_count SHALL increment by 1 on each RUN/DRAIN cycle in which pc_write=0, SHALL saturate at 16'hFFFF without wrap, and SHALL freeze in HALTED.
REQ-032 Latency: all responses SHALL be same-cycle (combinational); state and stall_count SHALL update at the next rising edge.

Reset
REQ-033 When reset_n=0 at a rising edge: state=RUN and stall_count=0.
REQ-034 While reset_n=0: pc_write=0, redirect=0, halted=0, all stalls 0, all flushes 1, regardless of other inputs.
REQ-035 Reset asserted in any state, including mid-DRAIN or mid-dwait, SHALL take priority and discard pending conditions.

Verification
REQ-036 Load-use: d_readM_EX=1, write_reg_addr_EX=2, rs_ID=2, use_rs_ID=1 for 1 cycle -> stall_IF_ID=1, flush_ID_EX=1, pc_write=0, stall_count 0->1; next cycle with d_readM_EX=0 -> all clear.
REQ-037 Mispredict with simultaneous lu -> redirect=1, flush_IF_ID=flush_ID_EX=1, pc_write=1, stall_IF_ID=0, stall_count unchanged.
REQ-038 d_access_MEM=1, d_ready=0 for 3 cycles with mispredict_EX=1 -> 3 cycles of REQ-022 outputs, redirect=0; cycle 4 with d_ready=1 -> redirect=1; stall_count=3.
REQ-039 halt_ID=1 with a clean pipeline -> DRAIN next cycle with pc_write=0; is_halted_WB=1 two cycles later -> halted=1, all stalls=1, held for 20 cycles.
REQ-040 stall_count preset to 16'hFFFE via 65534 iwait cycles, then 3 more iwait cycles -> stall_count=16'hFFFF and held.
REQ-041 reset_n=0 for 1 cycle while in DRAIN -> state RUN, stall_count=0, halted=0; outputs per REQ-034 during reset.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - pipeline stall/flush/redirect controller with halt drain
module pipeline_hazard_controller (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  rs_ID,
  input  logic [1:0]  rt_ID,
  input  logic        use_rs_ID,
  input  logic        use_rt_ID,
  input  logic        halt_ID,
  input  logic        d_readM_EX,
  input  logic [1:0]  write_reg_addr_EX,
  input  logic        mispredict_EX,
  input  logic        d_access_MEM,
  input  logic        d_ready,
  input  logic        i_ready,
  input  logic        is_halted_WB,
  output logic        pc_write,
  output logic        redirect,
  output logic        stall_IF_ID,
  output logic        stall_ID_EX,
  output logic        stall_EX_MEM,
  output logic        stall_MEM_WB,
  output logic        flush_IF_ID,
  output logic        flush_ID_EX,
  output logic        flush_EX_MEM,
  output logic        flush_MEM_WB,
  output logic        halted,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  state_t      r_state;
  logic [15:0] r_stall_count;

  logic w_dwait;
  logic w_lu;
  logic w_iwait;
  logic w_halt_go;

  assign w_dwait   = d_access_MEM & ~d_ready;
  assign w_lu      = d_readM_EX & ((use_rs_ID & (rs_ID == write_reg_addr_EX)) |
                                   (use_rt_ID & (rt_ID == write_reg_addr_EX)));
  assign w_iwait   = ~i_ready;
  // HLT may only move into EX when nothing ahead of it is holding or squashing ID
  assign w_halt_go = halt_ID & ~w_dwait & ~mispredict_EX & ~w_lu;

  assign stall_count = r_stall_count;

  // Same-cycle control decode: reset forces bubbles, otherwise one condition wins by priority
  always_comb begin
    pc_write     = 1'b0;
    redirect     = 1'b0;
    stall_IF_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_MEM = 1'b0;
    stall_MEM_WB = 1'b0;
    flush_IF_ID  = 1'b0;
    flush_ID_EX  = 1'b0;
    flush_EX_MEM = 1'b0;
    flush_MEM_WB = 1'b0;
    halted       = 1'b0;
    if (!reset_n) begin
      flush_IF_ID  = 1'b1;
      flush_ID_EX  = 1'b1;
      flush_EX_MEM = 1'b1;
      flush_MEM_WB = 1'b1;
    end else if (r_state == ST_HALTED) begin
      stall_IF_ID  = 1'b1;
      stall_ID_EX  = 1'b1;
      stall_EX_MEM = 1'b1;
      stall_MEM_WB = 1'b1;
      halted       = 1'b1;
    end else begin
      if (w_dwait) begin
        // memory stage owns the cycle; a pending mispredict stays in EX until it clears
        stall_IF_ID  = 1'b1;
        stall_ID_EX  = 1'b1;
        stall_EX_MEM = 1'b1;
        flush_MEM_WB = 1'b1;
      end else if (mispredict_EX) begin
        flush_IF_ID = 1'b1;
        flush_ID_EX = 1'b1;
        pc_write    = 1'b1;
        redirect    = 1'b1;
      end else if (w_lu) begin
        stall_IF_ID = 1'b1;
        flush_ID_EX = 1'b1;
      end else if (w_iwait) begin
        flush_IF_ID = 1'b1;
      end else begin
        pc_write = 1'b1;
      end
      // while draining, fetch is frozen and only bubbles enter ID
      if ((r_state == ST_DRAIN) && !w_dwait) begin
        pc_write    = 1'b0;
        stall_IF_ID = 1'b0;
        flush_IF_ID = 1'b1;
      end
    end
  end

  // State register and saturating stall counter (frozen once halted)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_RUN;
      r_stall_count <= 16'h0000;
    end else begin
      case (r_state)
        ST_RUN:   if (w_halt_go) r_state <= ST_DRAIN;
        ST_DRAIN: if (is_halted_WB) r_state <= ST_HALTED;
        default:  r_state <= ST_HALTED;
      endcase
      if ((r_state != ST_HALTED) && !pc_write && (r_stall_count != 16'hFFFF))
        r_stall_count <= r_stall_count + 16'h0001;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - scoreboard bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  rs_ID, rt_ID, write_reg_addr_EX;
  logic        use_rs_ID, use_rt_ID, halt_ID, d_readM_EX, mispredict_EX;
  logic        d_access_MEM, d_ready, i_ready, is_halted_WB;
  logic        pc_write, redirect, halted;
  logic        stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB;
  logic        flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  pipeline_hazard_controller dut (
    .clk(clk), .reset_n(reset_n),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .use_rs_ID(use_rs_ID), .use_rt_ID(use_rt_ID),
    .halt_ID(halt_ID), .d_readM_EX(d_readM_EX), .write_reg_addr_EX(write_reg_addr_EX),
    .mispredict_EX(mispredict_EX), .d_access_MEM(d_access_MEM), .d_ready(d_ready),
    .i_ready(i_ready), .is_halted_WB(is_halted_WB),
    .pc_write(pc_write), .redirect(redirect),
    .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
    .stall_EX_MEM(stall_EX_MEM), .stall_MEM_WB(stall_MEM_WB),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
    .flush_EX_MEM(flush_EX_MEM), .flush_MEM_WB(flush_MEM_WB),
    .halted(halted), .stall_count(stall_count)
  );

  // {pc_write, redirect, stall IF/ID/EX/MEM, flush IF/ID/EX/MEM, halted}
  localparam logic [10:0] E_NONE  = 11'b1_0_0000_0000_0;
  localparam logic [10:0] E_RST   = 11'b0_0_0000_1111_0;
  localparam logic [10:0] E_LU    = 11'b0_0_1000_0100_0;
  localparam logic [10:0] E_MISP  = 11'b1_1_0000_1100_0;
  localparam logic [10:0] E_DW    = 11'b0_0_1110_0001_0;
  localparam logic [10:0] E_IW    = 11'b0_0_0000_1000_0;
  localparam logic [10:0] E_DRAIN = 11'b0_0_0000_1000_0;
  localparam logic [10:0] E_HALT  = 11'b0_0_1111_0000_1;

  typedef struct {
    logic [10:0] ctrl;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic idle();
    reset_n = 1'b1; rs_ID = 2'd0; rt_ID = 2'd1; write_reg_addr_EX = 2'd3;
    use_rs_ID = 1'b0; use_rt_ID = 1'b0; halt_ID = 1'b0; d_readM_EX = 1'b0;
    mispredict_EX = 1'b0; d_access_MEM = 1'b0; d_ready = 1'b1; i_ready = 1'b1;
    is_halted_WB = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic expect_out(input logic [10:0] c, input logic [15:0] n, input string nm);
    exp_t e;
    e.ctrl = c; e.cnt = n; e.name = nm;
    q.push_back(e);
  endtask

  task automatic set_lu_rs();
    d_readM_EX = 1'b1; write_reg_addr_EX = 2'd2; rs_ID = 2'd2; use_rs_ID = 1'b1;
  endtask

  // Monitor: compares the DUT's outputs mid-cycle against the oldest queued expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [10:0] act;
      e = q.pop_front();
      act = {pc_write, redirect, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
             flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB, halted};
      checks++;
      if (act !== e.ctrl || stall_count !== e.cnt) begin
        errors++;
        $display("FAIL %s: ctrl=%b cnt=%h, expected ctrl=%b cnt=%h",
                 e.name, act, stall_count, e.ctrl, e.cnt);
      end
    end
  end

  initial begin
    idle();
    // reset with noisy inputs
    cyc(); reset_n = 0; mispredict_EX = 1; d_access_MEM = 1; d_ready = 0; i_ready = 0;
    cyc(); reset_n = 0; mispredict_EX = 1; d_access_MEM = 1; d_ready = 0; halt_ID = 1;
    expect_out(E_RST, 16'd0, "reset_outputs");
    cyc(); expect_out(E_NONE, 16'd0, "clean_after_reset");
    // load-use on rs, then on rt, and non-hazards
    cyc(); set_lu_rs(); expect_out(E_LU, 16'd0, "lu_rs");
    cyc(); expect_out(E_NONE, 16'd1, "lu_rs_clear");
    cyc(); d_readM_EX = 1; write_reg_addr_EX = 2'd3; rt_ID = 2'd3; use_rt_ID = 1;
    expect_out(E_LU, 16'd1, "lu_rt");
    cyc(); expect_out(E_NONE, 16'd2, "lu_rt_clear");
    cyc(); set_lu_rs(); use_rs_ID = 0; expect_out(E_NONE, 16'd2, "no_lu_unused_rs");
    cyc(); set_lu_rs(); d_readM_EX = 0; expect_out(E_NONE, 16'd2, "no_lu_not_load");
    // mispredict beats load-use
    cyc(); set_lu_rs(); mispredict_EX = 1; expect_out(E_MISP, 16'd2, "misp_over_lu");
    cyc(); expect_out(E_NONE, 16'd2, "misp_clear");
    // iwait and priority stacking
    cyc(); i_ready = 0; expect_out(E_IW, 16'd2, "iwait");
    cyc(); set_lu_rs(); i_ready = 0; expect_out(E_LU, 16'd3, "lu_over_iwait");
    cyc(); set_lu_rs(); i_ready = 0; mispredict_EX = 1; d_access_MEM = 1; d_ready = 0;
    expect_out(E_DW, 16'd4, "dwait_over_all");
    cyc(); expect_out(E_NONE, 16'd5, "stack_clear");
    // dwait holding a mispredict for three cycles
    cyc(); reset_n = 0; expect_out(E_RST, 16'd5, "reset2");
    for (int i = 0; i < 3; i++) begin
      cyc(); d_access_MEM = 1; d_ready = 0; mispredict_EX = 1;
      expect_out(E_DW, 16'(i), "dwait_hold_misp");
    end
    cyc(); d_access_MEM = 1; d_ready = 1; mispredict_EX = 1;
    expect_out(E_MISP, 16'd3, "misp_after_dwait");
    cyc(); expect_out(E_NONE, 16'd3, "after_misp");
    // halt blocked by load-use, then drain and halt
    cyc(); set_lu_rs(); halt_ID = 1; expect_out(E_LU, 16'd3, "halt_blocked_lu");
    cyc(); halt_ID = 1; expect_out(E_NONE, 16'd4, "halt_enter");
    cyc(); expect_out(E_DRAIN, 16'd4, "drain1");
    cyc(); mispredict_EX = 0; i_ready = 1; expect_out(E_DRAIN, 16'd5, "drain2");
    cyc(); is_halted_WB = 1; expect_out(E_DRAIN, 16'd6, "drain_wb");
    for (int i = 0; i < 20; i++) begin
      cyc(); i_ready = 0; d_access_MEM = 1; d_ready = 0; set_lu_rs();
      expect_out(E_HALT, 16'd7, "halted_hold");
    end
    // reset mid-drain
    cyc(); reset_n = 0; expect_out(E_RST, 16'd7, "reset3");
    cyc(); halt_ID = 1; expect_out(E_NONE, 16'd0, "halt_enter2");
    cyc(); expect_out(E_DRAIN, 16'd0, "drain_before_reset");
    cyc(); reset_n = 0; is_halted_WB = 1; expect_out(E_RST, 16'd1, "reset_in_drain");
    cyc(); expect_out(E_NONE, 16'd0, "run_after_drain_reset");
    cyc(); expect_out(E_NONE, 16'd0, "still_run");
    // saturation
    for (int i = 0; i < 65534; i++) begin
      cyc(); i_ready = 0;
    end
    cyc(); i_ready = 0; expect_out(E_IW, 16'hFFFE, "sat_fffe");
    cyc(); i_ready = 0; expect_out(E_IW, 16'hFFFF, "sat_ffff");
    cyc(); i_ready = 0; expect_out(E_IW, 16'hFFFF, "sat_hold1");
    cyc(); expect_out(E_NONE, 16'hFFFF, "sat_hold2");
    cyc();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
